// File: rtl/fast_to_slow.sv
// fast_to_slow: 2-phase toggle handshake carrying a held data word from fast_clk to slow_clk
module fast_to_slow #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             slow_clk,
  input  logic             reset_1,
  input  logic             fast_clk,
  input  logic             i_fast_valid,
  input  logic [WIDTH-1:0] i_fast_data,
  output logic             o_fast_ready,
  output logic             o_fast_drop,
  output logic             o_slow_valid,
  output logic [WIDTH-1:0] o_slow_data
);
  logic [1:0]             r_frst;
  logic                   w_frst;
  logic                   r_req_tgl;
  logic [SYNC_STAGES-1:0] r_ack_s;
  logic [WIDTH-1:0]       r_hold;
  logic                   r_fast_ready;
  logic                   r_fast_drop;
  logic                   w_accept;
  logic [SYNC_STAGES-1:0] r_req_s;
  logic                   r_req_d;
  logic                   r_ack_tgl;
  logic                   r_slow_valid;
  logic [WIDTH-1:0]       r_slow_data;
  logic                   w_toggle;
  assign w_frst       = r_frst[1];
  assign w_accept     = i_fast_valid & r_fast_ready;
  assign w_toggle     = r_req_s[SYNC_STAGES-1] ^ r_req_d;
  assign o_fast_ready = r_fast_ready;
  assign o_fast_drop  = r_fast_drop;
  assign o_slow_valid = r_slow_valid;
  assign o_slow_data  = r_slow_data;
  // fast-domain reset: asserts with reset_1, releases two fast edges later
  always_ff @(posedge fast_clk or posedge reset_1)
    if (reset_1) r_frst <= 2'b11;
    else         r_frst <= {r_frst[0], 1'b0};
  // fast side: accept into hold only when the previous toggle has been acknowledged
  always_ff @(posedge fast_clk or posedge w_frst)
    if (w_frst) begin
      r_req_tgl    <= 1'b0;
      r_ack_s      <= '0;
      r_hold       <= '0;
      r_fast_ready <= 1'b0;
      r_fast_drop  <= 1'b0;
    end else begin
      r_ack_s      <= {r_ack_s[SYNC_STAGES-2:0], r_ack_tgl};
      r_fast_drop  <= i_fast_valid & ~r_fast_ready;
      r_fast_ready <= ~w_accept & (r_ack_s[SYNC_STAGES-1] == r_req_tgl);
      if (w_accept) begin
        r_hold    <= i_fast_data;
        r_req_tgl <= ~r_req_tgl;
      end
    end
  // slow side: detect the synced request toggle, capture the stable hold word, acknowledge
  always_ff @(posedge slow_clk or posedge reset_1)
    if (reset_1) begin
      r_req_s      <= '0;
      r_req_d      <= 1'b0;
      r_ack_tgl    <= 1'b0;
      r_slow_valid <= 1'b0;
      r_slow_data  <= '0;
    end else begin
      r_req_s      <= {r_req_s[SYNC_STAGES-2:0], r_req_tgl};
      r_req_d      <= r_req_s[SYNC_STAGES-1];
      r_slow_valid <= w_toggle;
      if (w_toggle) begin
        r_slow_data <= r_hold;
        r_ack_tgl   <= r_req_s[SYNC_STAGES-1];
      end
    end
endmodule

// File: tb/tb_fast_to_slow.sv
// tb_fast_to_slow: scoreboard bench for two fast_to_slow instances (2 and 3 sync stages)
`timescale 1ns/1ps
module tb_fast_to_slow;
  logic       slow_clk = 1'b0;
  logic       fast_clk = 1'b0;
  logic       reset_1 = 1'b1;
  logic       fast_valid = 1'b0;
  logic [7:0] fast_data = 8'h00;
  logic [1:0] fast_ready, fast_drop, slow_valid;
  logic [7:0] slow_data [2];
  real        tf_half = 5.0;
  real        ts_half = 20.0;
  real        ts_skew = 0.0;
  int         n_cmp = 0;
  int         n_err = 0;
  always #(tf_half) fast_clk = ~fast_clk;
  always begin
    #(ts_half + ts_skew);
    ts_skew = 0.0;
    slow_clk = ~slow_clk;
  end
  fast_to_slow #(.WIDTH(8), .SYNC_STAGES(2)) u_dut2 (
    .slow_clk(slow_clk), .reset_1(reset_1), .fast_clk(fast_clk),
    .i_fast_valid(fast_valid), .i_fast_data(fast_data),
    .o_fast_ready(fast_ready[0]), .o_fast_drop(fast_drop[0]),
    .o_slow_valid(slow_valid[0]), .o_slow_data(slow_data[0]));
  fast_to_slow #(.WIDTH(8), .SYNC_STAGES(3)) u_dut3 (
    .slow_clk(slow_clk), .reset_1(reset_1), .fast_clk(fast_clk),
    .i_fast_valid(fast_valid), .i_fast_data(fast_data),
    .o_fast_ready(fast_ready[1]), .o_fast_drop(fast_drop[1]),
    .o_slow_valid(slow_valid[1]), .o_slow_data(slow_data[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  for (genvar k = 0; k < 2; k++) begin : g_mon
    logic [7:0] q[$];
    logic       exp_drop = 1'b0;
    logic       prev_sv = 1'b0;
    int         n_acc = 0;
    int         n_sv = 0;
    always @(negedge fast_clk)
      if (reset_1) begin
        q.delete();
        exp_drop = 1'b0;
      end else begin
        if (exp_drop || fast_drop[k]) chk($sformatf("drop%0d", k), 32'(fast_drop[k]), 32'(exp_drop));
        exp_drop = fast_valid & ~fast_ready[k];
        if (fast_valid & fast_ready[k]) begin
          q.push_back(fast_data);
          n_acc++;
        end
      end
    always @(negedge slow_clk) begin
      if (slow_valid[k]) begin
        n_sv++;
        chk($sformatf("vwidth%0d", k), 32'(prev_sv), 0);
        if (q.size() == 0) chk($sformatf("spurious%0d", k), 32'(slow_valid[k]), 0);
        else chk($sformatf("data%0d", k), 32'(slow_data[k]), 32'(q.pop_front()));
      end
      prev_sv = slow_valid[k];
    end
  end
  task automatic wait_ready(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!fast_ready[0] && n < max_cyc) begin
      @(negedge fast_clk);
      n++;
    end
    chk(tag, 32'(fast_ready[0]), 1);
  endtask
  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((g_mon[0].q.size() + g_mon[1].q.size()) != 0 && n < max_cyc) begin
      @(negedge slow_clk);
      n++;
    end
    chk(tag, 32'(g_mon[0].q.size() + g_mon[1].q.size()), 0);
    repeat (6) @(negedge slow_clk);
  endtask
  task automatic write(input logic [7:0] d);
    @(posedge fast_clk);
    #1 fast_valid = 1'b1;
    fast_data = d;
    @(posedge fast_clk);
    #1 fast_valid = 1'b0;
  endtask
  task automatic sweep(input real half, input int words);
    int start, n;
    ts_half = half;
    ts_skew = real'($urandom_range(0, 30)) * 0.37;
    start = g_mon[0].n_acc;
    n = 0;
    while (g_mon[0].n_acc < start + words && n < 30000) begin
      @(posedge fast_clk);
      #1 fast_valid = 1'($urandom_range(0, 1));
      fast_data = 8'($urandom);
      n++;
    end
    @(posedge fast_clk);
    #1 fast_valid = 1'b0;
    chk("sweep_words", 32'(g_mon[0].n_acc - start >= words), 1);
    drain("sweep_drain", 400);
  endtask
  initial begin
    int n, cyc, sv0;
    logic acc;
    repeat (5) @(posedge slow_clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(fast_ready[k]), 0);
      chk("rst_drop", 32'(fast_drop[k]), 0);
      chk("rst_svalid", 32'(slow_valid[k]), 0);
      chk("rst_sdata", 32'(slow_data[k]), 0);
    end
    @(negedge slow_clk);
    reset_1 = 1'b0;
    wait_ready("rst_release_ready", 4);
    repeat (8) @(negedge slow_clk);
    write(8'hA5);
    n = 0;
    while (!slow_valid[0] && n < 5) begin
      @(negedge slow_clk);
      n++;
    end
    chk("single_arrive", 32'(slow_valid[0]), 1);
    wait_ready("single_ready_ret", 6);
    drain("single_drain", 50);
    chk("single_hold", 32'(slow_data[0]), 32'h A5);
    sv0 = g_mon[0].n_sv;
    fast_data = 8'h00;
    n = 0;
    cyc = 0;
    @(posedge fast_clk);
    #1 fast_valid = 1'b1;
    while (n < 16 && cyc < 3000) begin
      @(negedge fast_clk);
      acc = fast_ready[0];
      @(posedge fast_clk);
      #1;
      if (acc) begin
        n++;
        fast_data = 8'(n);
      end
      if (n == 16) fast_valid = 1'b0;
      cyc++;
    end
    fast_valid = 1'b0;
    chk("stream_accepts", 32'(n), 16);
    drain("stream_drain", 200);
    chk("stream_pulses", 32'(g_mon[0].n_sv - sv0), 16);
    wait_ready("drop_pre_ready", 20);
    sv0 = g_mon[0].n_sv;
    @(posedge fast_clk);
    #1 fast_valid = 1'b1;
    fast_data = 8'hA5;
    @(posedge fast_clk);
    #1 fast_data = 8'h3C;
    @(posedge fast_clk);
    #1 fast_valid = 1'b0;
    drain("drop_drain", 50);
    chk("drop_pulses", 32'(g_mon[0].n_sv - sv0), 1);
    chk("drop_hold", 32'(slow_data[0]), 32'h A5);
    wait_ready("mid_pre_ready", 20);
    write(8'h77);
    @(posedge slow_clk);
    @(posedge slow_clk);
    #1 reset_1 = 1'b1;
    repeat (3) @(posedge slow_clk);
    #1;
    chk("mid_sdata", 32'(slow_data[0]), 0);
    chk("mid_ready", 32'(fast_ready[0]), 0);
    @(negedge slow_clk);
    reset_1 = 1'b0;
    wait_ready("mid_release_ready", 4);
    sv0 = g_mon[0].n_sv;
    repeat (12) @(negedge slow_clk);
    chk("mid_no_pulse", 32'(g_mon[0].n_sv - sv0), 0);
    write(8'h11);
    drain("mid_drain", 50);
    chk("mid_next", 32'(slow_data[0]), 32'h11);
    sweep(6.5, 400);
    sweep(20.0, 400);
    sweep(85.0, 200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
